// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store sequencer:
//   - 3-bit access op codes
//   - FSM state encoding
//   - is_store / is_aligned helper predicates
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Stores occupy the top three codes.
    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] off);
        logic ok;
        case (op)
            OP_LW, OP_SW:         ok = (off == 2'b00);
            OP_LH, OP_LHU, OP_SH: ok = (off[0] == 1'b0);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane logic for a 32-bit little-endian word.
//   i_mdr        : word read from memory (or about to be latched into MDR)
//   i_store_data : CPU store source; low lanes used for SH/SB
//   i_op         : access op code
//   i_offset     : byte offset within the word (ByteAddr[1:0])
//   o_merged     : word to write back (SW: store data, SH/SB: MDR with lane
//                  replaced, loads: MDR unchanged)
//   o_load_data  : selected lane, sign/zero-extended (0 for stores)
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_mdr,
    input  logic [31:0] i_store_data,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_offset[1] ? i_mdr[31:16] : i_mdr[15:0];
    assign w_byte = 8'(i_mdr >> {i_offset, 3'b000});

    always_comb begin
        o_merged = i_mdr;
        case (i_op)
            OP_SW: o_merged = i_store_data;
            OP_SH: begin
                if (i_offset[1]) o_merged[31:16] = i_store_data[15:0];
                else             o_merged[15:0]  = i_store_data[15:0];
            end
            OP_SB: begin
                case (i_offset)
                    2'd0:    o_merged[7:0]   = i_store_data[7:0];
                    2'd1:    o_merged[15:8]  = i_store_data[7:0];
                    2'd2:    o_merged[23:16] = i_store_data[7:0];
                    default: o_merged[31:24] = i_store_data[7:0];
                endcase
            end
            default: o_merged = i_mdr;
        endcase
    end

    always_comb begin
        o_load_data = 32'd0;
        case (i_op)
            OP_LW:   o_load_data = i_mdr;
            OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load_data = {16'd0, w_half};
            OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load_data = {24'd0, w_byte};
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store sequencer between the CPU datapath and word-addressed DMem.
// One byte-addressed access per Start; sub-word stores as read-modify-write.
//   Clk, Reset_n  : clock, async active-low reset
//   Start         : request strobe, only honoured in IDLE
//   Op            : access op code (mem_access_pkg)
//   ByteAddr      : CPU byte address, latched with Start
//   StoreData     : store source, latched with Start
//   Busy          : high whenever not IDLE
//   Done          : one-cycle completion pulse
//   Misaligned    : result flag, held until next accepted Start
//   LoadData      : extended load result, held until next completion
//   MemAddress    : word address to DMem (latched ByteAddr >> 2)
//   MemWriteData  : write word to DMem
//   MemWrite      : DMem write enable (WRITE state only)
//   MemData       : DMem read data (combinational from MemAddress)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for Start
// READ  | MemData captured into MDR (loads, SH/SB)
// WRITE | MemWrite asserted with SW data or merged SH/SB word
// DONE  | Done pulse, LoadData/Misaligned valid
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32     // lane logic is fixed at 32
)(
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic [2:0]               Op,
    input  logic [ADDRESS_WIDTH-1:0] ByteAddr,
    input  logic [DATA_WIDTH-1:0]    StoreData,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Misaligned,
    output logic [DATA_WIDTH-1:0]    LoadData,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [2:0]                 r_op;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]      r_store_data;
    logic [DATA_WIDTH-1:0]      r_mdr;
    logic [DATA_WIDTH-1:0]      r_load_data;
    logic                       r_misaligned;

    logic                       w_aligned;
    logic [DATA_WIDTH-1:0]      w_mdr_src;
    logic [DATA_WIDTH-1:0]      w_merged;
    logic [DATA_WIDTH-1:0]      w_extract;

    assign w_aligned = is_aligned(Op, ByteAddr[1:0]);

    // LoadData is registered on the same edge that captures MDR, so the
    // extractor looks at the incoming read data while in READ.
    assign w_mdr_src = (r_state == READ) ? MemData : r_mdr;

    mem_lane_align u_lane (
        .i_mdr        (w_mdr_src),
        .i_store_data (r_store_data),
        .i_op         (r_op),
        .i_offset     (r_addr[1:0]),
        .o_merged     (w_merged),
        .o_load_data  (w_extract)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (!w_aligned)       w_next_state = DONE;
                    else if (Op == OP_SW) w_next_state = WRITE;
                    else                  w_next_state = READ;
                end
            end
            READ:    w_next_state = is_store(r_op) ? WRITE : DONE;
            WRITE:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_op         <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_mdr        <= '0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (r_state == IDLE && Start) begin
                r_op         <= Op;
                r_addr       <= ByteAddr;
                r_store_data <= StoreData;
                r_misaligned <= !w_aligned;
            end

            if (r_state == READ) begin
                r_mdr <= MemData;
            end

            // Only a load leaving READ produces data; every other entry to
            // DONE (misaligned, store) returns zero.
            if (r_state == READ && w_next_state == DONE) begin
                r_load_data <= w_extract;
            end else if (r_state != DONE && w_next_state == DONE) begin
                r_load_data <= '0;
            end
        end
    end

    assign Busy         = (r_state != IDLE);
    assign Done         = (r_state == DONE);
    assign MemWrite     = (r_state == WRITE);
    assign Misaligned   = r_misaligned;
    assign LoadData     = r_load_data;
    assign MemAddress   = {2'b00, r_addr[ADDRESS_WIDTH-1:2]};
    assign MemWriteData = w_merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboarded bench for mem_access_unit with a 16-word behavioural DMem.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] ByteAddr = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic        Busy, Done, Misaligned, MemWrite;
    logic [31:0] LoadData, MemAddress, MemWriteData, MemData;

    always #5 Clk = ~Clk;

    mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Op           (Op),
        .ByteAddr     (ByteAddr),
        .StoreData    (StoreData),
        .Busy         (Busy),
        .Done         (Done),
        .Misaligned   (Misaligned),
        .LoadData     (LoadData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemData      (MemData)
    );

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    bit          tb_init_done = 1'b0;

    always @(posedge Clk) begin
        if (!tb_init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (MemWrite) begin
            mem[MemAddress[3:0]] <= MemWriteData;
        end
    end

    assign MemData = mem[MemAddress[3:0]];

    typedef struct {
        int          lat;
        logic        mis;
        logic [31:0] ld;
        int          writes;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_mis(input logic [2:0] op, input logic [1:0] off);
        if (op == OP_LW || op == OP_SW) return off != 2'b00;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return off[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w,
                                               input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (8 * int'(off));
        case (op)
            OP_LW:   return w;
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return sh & 32'h0000_FFFF;
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return sh & 32'h0000_00FF;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] op, input logic [31:0] w,
                                                input logic [31:0] sd, input logic [1:0] off);
        logic [31:0] mask;
        int          s;
        s = 8 * int'(off);
        if (op == OP_SW) return sd;
        mask = (op == OP_SH) ? 32'h0000_FFFF : 32'h0000_00FF;
        return (w & ~(mask << s)) | ((sd & mask) << s);
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input bit hold, input string name);
        exp_t e;
        exp_t g;
        int   idx;
        int   cyc;
        int   wr;
        bit   done_seen;

        idx      = int'(addr[5:2]);
        e.mis    = model_mis(op, addr[1:0]);
        e.lat    = e.mis ? 1 : ((op == OP_SH || op == OP_SB) ? 3 : 2);
        e.ld     = e.mis ? 32'd0 : model_load(op, ref_mem[idx], addr[1:0]);
        e.writes = (!e.mis && (op == OP_SW || op == OP_SH || op == OP_SB)) ? 1 : 0;
        e.maddr  = addr >> 2;
        if (e.writes == 1) ref_mem[idx] = model_store(op, ref_mem[idx], sd, addr[1:0]);
        sb_q.push_back(e);

        @(negedge Clk);
        Op = op; ByteAddr = addr; StoreData = sd; Start = 1'b1;
        @(posedge Clk);
        if (!hold) #1 Start = 1'b0;

        cyc = 1; wr = 0; done_seen = 1'b0;
        @(negedge Clk);
        while (1) begin
            if (MemWrite) wr++;
            if (Done) begin
                done_seen = 1'b1;
                break;
            end
            if (cyc >= 8) break;
            @(posedge Clk);
            @(negedge Clk);
            cyc++;
        end

        if (!done_seen) check({name, "_done_timeout"}, 32'(Done), 32'd1);
        if (sb_q.size() > 0) begin
            g = sb_q.pop_front();
            check({name, "_latency"},    32'(cyc),        32'(g.lat));
            check({name, "_misaligned"}, 32'(Misaligned), 32'(g.mis));
            check({name, "_loaddata"},   LoadData,        g.ld);
            check({name, "_memwrites"},  32'(wr),         32'(g.writes));
            check({name, "_memaddr"},    MemAddress,      g.maddr);
        end

        if (hold) begin
            @(posedge Clk);
            #1 Start = 1'b0;
        end
        @(negedge Clk);
        check({name, "_done_pulse"}, 32'(Done), 32'd0);
        check({name, "_idle_after"}, 32'(Busy), 32'd0);
        check({name, "_mem_word"},   mem[idx],  ref_mem[idx]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);

        // Reset held 3 cycles; preload memory meanwhile
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy",     32'(Busy),     32'd0);
        check("rst_done",     32'(Done),     32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_loaddata", LoadData,      32'd0);
        check("rst_memaddr",  MemAddress,    32'd0);
        Reset_n = 1'b1;
        tb_init_done = 1'b1;
        repeat (2) @(posedge Clk);
        check("rel_busy",     32'(Busy),     32'd0);
        check("rel_loaddata", LoadData,      32'd0);

        do_op(OP_LW, 32'h08, 32'h0, 1'b0, "lw_first");

        // SW then LW
        do_op(OP_SW, 32'h08, 32'hDEAD_BEEF, 1'b0, "sw_08");
        do_op(OP_LW, 32'h08, 32'h0, 1'b0, "lw_08");
        check("lw_08_literal", LoadData, 32'hDEAD_BEEF);

        // Sub-word stores (upper store bits must be ignored)
        do_op(OP_SW, 32'h08, 32'h1122_3344, 1'b0, "sw_init");
        do_op(OP_SB, 32'h09, 32'hFFFF_FF5A, 1'b0, "sb_09");
        check("sb_09_literal", mem[2], 32'h1122_5A44);
        do_op(OP_SH, 32'h0A, 32'h1234_BEEF, 1'b0, "sh_0a");
        check("sh_0a_literal", mem[2], 32'hBEEF_5A44);

        // Sub-word loads
        do_op(OP_SW,  32'h0C, 32'h80FF_7F01, 1'b0, "sw_0c");
        do_op(OP_LB,  32'h0F, 32'h0, 1'b0, "lb_0f");
        check("lb_0f_literal", LoadData, 32'hFFFF_FF80);
        do_op(OP_LBU, 32'h0F, 32'h0, 1'b0, "lbu_0f");
        check("lbu_0f_literal", LoadData, 32'h0000_0080);
        do_op(OP_LH,  32'h0C, 32'h0, 1'b0, "lh_0c");
        check("lh_0c_literal", LoadData, 32'h0000_7F01);
        do_op(OP_LHU, 32'h0E, 32'h0, 1'b0, "lhu_0e");
        check("lhu_0e_literal", LoadData, 32'h0000_80FF);
        do_op(OP_LH,  32'h0E, 32'h0, 1'b0, "lh_0e");
        do_op(OP_LB,  32'h0D, 32'h0, 1'b0, "lb_0d");

        // Misaligned accesses
        do_op(OP_LW, 32'h06, 32'h0, 1'b0, "lw_mis");
        do_op(OP_SH, 32'h05, 32'hAAAA_5555, 1'b0, "sh_mis");
        check("sh_mis_literal", mem[1], 32'h1000_0001);
        do_op(OP_SW, 32'h0D, 32'h0BAD_0BAD, 1'b0, "sw_mis");

        // Start held through READ/WRITE/DONE must be ignored
        do_op(OP_SB, 32'h0C, 32'h0000_0033, 1'b1, "sb_hold");
        do_op(OP_LW, 32'h0C, 32'h0, 1'b1, "lw_hold");
        @(negedge Clk);
        check("hold_no_second_op", 32'(Busy), 32'd0);

        // Reset asserted mid-WRITE of an SB
        do_op(OP_SW, 32'h10, 32'h0102_0304, 1'b0, "sw_10");
        @(negedge Clk);
        Op = OP_SB; ByteAddr = 32'h11; StoreData = 32'h0000_00AA; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(posedge Clk);
        #1;
        check("rstw_in_write", 32'(MemWrite), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rstw_memwrite", 32'(MemWrite),  32'd0);
        check("rstw_busy",     32'(Busy),      32'd0);
        check("rstw_done",     32'(Done),      32'd0);
        check("rstw_memaddr",  MemAddress,     32'd0);
        check("rstw_wdata",    MemWriteData,   32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("rstw_mem_word", mem[4], 32'h0102_0304);
        Reset_n = 1'b1;

        do_op(OP_LW, 32'h10, 32'h0, 1'b0, "lw_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
